// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type, line levels and bus timing for the I2C pair.
// Shared between i2c_target and the team's I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_ACK
  } i2c_target_state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  localparam int LOW_CYCLES          = 673;
  localparam int HIGH_CYCLES         = 577;
  localparam int MINIMUM_HOLD_CYCLES = 75;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer, optional glitch filter, edge detect.
// Filter is built only when I2C_GLITCH_FILTER_EN is defined.
module i2c_line_sync #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       filt;
  logic       prev;

  if (FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("FILTER_CYCLES must be at least 1");
  end

  // Lines idle high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pin};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      filt <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign filt = sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= filt;
    end
  end

  assign level = filt;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C target with auto-incrementing register pointer.
// Optional SCL/SDA glitch filter: define I2C_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int PTR_W           = 8,
  parameter int SDA_HOLD_CYCLES = 30,
  parameter int FILTER_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_pin,
  inout  wire              sda_pin,
  input  logic [6:0]       own_addr,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  input  logic [7:0]       reg_rdata,
  output logic             busy,
  output logic             xfer_done
);

  localparam logic [3:0] S_IDLE     = IDLE;
  localparam logic [3:0] S_ADDR     = ADDR;
  localparam logic [3:0] S_ADDR_ACK = ADDR_ACK;
  localparam logic [3:0] S_PTR      = PTR;
  localparam logic [3:0] S_PTR_ACK  = PTR_ACK;
  localparam logic [3:0] S_WRITE    = WRITE;
  localparam logic [3:0] S_WR_ACK   = WR_ACK;
  localparam logic [3:0] S_READ     = READ;
  localparam logic [3:0] S_RD_ACK   = RD_ACK;

  localparam int HW = $clog2(SDA_HOLD_CYCLES + 1);

  logic             scl_lvl, scl_rise, scl_fall;
  logic             sda_lvl, sda_rise, sda_fall;
  logic             start_det, stop_det;
  logic [3:0]       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       rx_byte;
  logic [6:0]       addr_q;
  logic             rw;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe;
  logic             pend_oe;
  logic             hold_act;
  logic [HW-1:0]    hold_cnt;

  i2c_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk   (clk),
    .reset (reset),
    .pin   (scl_pin),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk   (clk),
    .reset (reset),
    .pin   (sda_pin),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign rx_byte   = {shreg[6:0], sda_lvl};
  assign reg_addr  = ptr;
  assign sda_pin   = sda_oe ? ACK_LVL : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      pend_oe   <= 1'b0;
      hold_act  <= 1'b0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      xfer_done <= 1'b0;
      reg_we    <= 1'b0;
      if (reg_we) ptr <= ptr + PTR_W'(1);
      // SDA only moves once the hold time after SCL fall has elapsed.
      if (hold_act) begin
        if (hold_cnt == '0) begin
          sda_oe   <= pend_oe;
          hold_act <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end
      if (start_det) begin
        state    <= S_ADDR;
        bit_cnt  <= '0;
        addr_q   <= own_addr;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        hold_act <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        xfer_done <= busy;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        hold_act  <= 1'b0;
      end else if (scl_rise) begin
        unique case (state)
          S_ADDR, S_PTR, S_WRITE: begin
            if (bit_cnt != 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (bit_cnt == 4'd7 && state == S_ADDR) begin
              rw <= rx_byte[0];
              if (rx_byte[7:1] != addr_q) state <= S_IDLE;
            end
            if (bit_cnt == 4'd7 && state == S_WRITE) begin
              reg_we    <= 1'b1;
              reg_wdata <= rx_byte;
            end
          end
          S_READ: begin
            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
          end
          S_RD_ACK: begin
            if (sda_lvl == NACK_LVL) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        hold_act <= 1'b1;
        hold_cnt <= HW'(SDA_HOLD_CYCLES - 1);
        pend_oe  <= 1'b0;
        unique case (state)
          S_ADDR: begin
            if (bit_cnt == 4'd8) begin
              state   <= S_ADDR_ACK;
              busy    <= 1'b1;
              pend_oe <= 1'b1;
            end
          end
          S_ADDR_ACK, S_RD_ACK: begin
            bit_cnt <= '0;
            if (rw) begin
              state   <= S_READ;
              shreg   <= reg_rdata;
              ptr     <= ptr + PTR_W'(1);
              pend_oe <= !reg_rdata[7];
            end else begin
              state <= S_PTR;
            end
          end
          S_PTR: begin
            if (bit_cnt == 4'd8) begin
              ptr     <= PTR_W'(shreg);
              state   <= S_PTR_ACK;
              pend_oe <= 1'b1;
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            state   <= S_WRITE;
            bit_cnt <= '0;
          end
          S_WRITE: begin
            if (bit_cnt == 4'd8) begin
              state   <= S_WR_ACK;
              pend_oe <= 1'b1;
            end
          end
          S_READ: begin
            if (bit_cnt == 4'd8) begin
              state   <= S_RD_ACK;
              bit_cnt <= '0;
            end else begin
              shreg   <= {shreg[6:0], 1'b1};
              pend_oe <= !shreg[6];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint that responds to transactions from the team's I2C master on the shared SCL/SDA bus.
- Matches a 7-bit address and holds a register pointer that auto-increments.
- Write transactions set the pointer and write data bytes to a register port; read transactions return bytes from that port.
- SDA is open-drain only (low or released). SCL is observed, never driven; there is no clock stretching.

Parameters:
PTR_W, 8, register pointer width; pointer wraps modulo 2^PTR_W.
SDA_HOLD_CYCLES, 30, clk cycles after a detected SCL falling edge before SDA is changed.
FILTER_CYCLES, 4, pin-stable cycles required by the glitch filter (used only with I2C_GLITCH_FILTER_EN).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
scl_pin  input  1  SCL line (observed only).
sda_pin  inout  1  SDA line; driven 1'b0 or 1'bz only.
own_addr  input  7  target address; sampled when a START is detected.
reg_addr  output  PTR_W  current register pointer.
reg_wdata  output  8  write data, valid with reg_we.
reg_we  output  1  one-cycle write strobe.
reg_rdata  input  8  read data for reg_addr; must be valid 2 cycles after reg_addr changes.
busy  output  1  high from our address ACK until STOP, repeated START, or master NACK.
xfer_done  output  1  one-cycle pulse on STOP ending a transaction in which we were addressed.

Behaviour:
- Reset values: SDA released, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, xfer_done=0, state IDLE. Reset mid-transfer releases SDA in the next cycle.
- Input path:
  - SCL and SDA each pass through a 2-flop synchronizer plus one previous-sample flop.
  - Edge and condition flags are asserted 3 clk after a pin change.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit timing:
  - Sample SDA on SCL rising.
  - Change the SDA drive SDA_HOLD_CYCLES after SCL falling.
  - Bits are MSB first.
- STOP or START has priority over everything else in every state.
  - A START at any point (repeated START) aborts the current byte, clears busy, and enters ADDR. The pointer is retained.
  - A STOP at any point goes to IDLE, releases SDA, and discards any partial byte with no reg_we. xfer_done pulses if busy was high.
- States:
  - IDLE: ignore the bus until START.
  - ADDR: shift 8 bits.
    - If bits[7:1] == own_addr, go to ADDR_ACK.
    - Otherwise go to IDLE and do not drive SDA until the next START.
  - ADDR_ACK: drive low for one SCL low+high period (from the falling edge after bit 8 to the next falling edge). Set busy.
    - If R/W=0, go to PTR.
    - If R/W=1, go to READ and load reg_rdata at the ACK-ending falling edge.
  - PTR: shift 8 bits. The low PTR_W bits load the pointer, then go to PTR_ACK (ACK always).
  - PTR_ACK: drive the ACK, then go to WRITE.
  - WRITE: shift 8 bits. In the cycle after the 8th rising edge: reg_we=1, reg_wdata=byte, reg_addr=pointer. The pointer increments the next cycle. Go to WR_ACK (ACK always).
  - WR_ACK: drive the ACK, then go to WRITE.
  - READ: drive 8 bits from the loaded byte. Release SDA on the falling edge after bit 8, then go to RD_ACK. The pointer increments when the byte is loaded.
  - RD_ACK: sample the master's bit on SCL rising.
    - 0: reload from reg_rdata at the next falling edge and go to READ.
    - 1 (NACK): release SDA, clear busy, go to IDLE and wait for STOP or START.
- Pointer wrap: 2^PTR_W-1 increments to 0.
- Simultaneous events: a START/STOP flag and an SCL edge cannot occur in the same cycle (SCL is high during START/STOP). If they do, START/STOP wins.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined: after synchronization, each line's filtered value updates only after the raw value has been stable for FILTER_CYCLES consecutive clks. Edge and condition flags are therefore delayed by an extra FILTER_CYCLES.
- Undefined: the filter is bypassed, FILTER_CYCLES is unused, and latency is 3 clk as stated above.

Decomposition:
- Shared package i2c_pkg holds:
  - i2c_target_state_t enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RD_ACK).
  - ACK/NACK level constants.
  - Bus timing constants LOW_CYCLES=673, HIGH_CYCLES=577, MINIMUM_HOLD_CYCLES=75, shared with the master.
- One sub-module: i2c_line_sync. Per line it contains the synchronizer, the optional filter, and the rise/fall detect. It is instantiated for SCL and for SDA; the top module derives START/STOP from the two.

Test Plan:
- own_addr=7'h42; master writes 0x84, 0x10, 0xAA, 0x55, STOP -> ACK on all 4 bytes; reg_we pulses twice: (0x10, 0xAA), then (0x11, 0x55); xfer_done pulses once.
- Write pointer 0x20, repeated START, read 3 bytes with model reg_rdata=addr^0xFF, master NACKs the 3rd -> bytes 0xDF, 0xDE, 0xDD on SDA; SDA released after the NACK; busy=0.
- Address 0x43 sent while own_addr=0x42 -> SDA never driven low; no reg_we; busy stays 0.
- Pointer 0xFF, write 2 bytes -> reg_we at addr 0xFF then 0x00 (wrap).
- STOP after 5 bits of a data byte -> no reg_we, state IDLE, SDA released; assert reset mid-ACK -> SDA released 1 cycle later, all outputs at reset values.
- With I2C_GLITCH_FILTER_EN: 2-cycle low glitch on SCL during a data bit -> ignored, byte received correctly; without the macro the same glitch corrupts the bit count (check is expected-fail/informational).
